// File: rtl/eth_tx_noc_arbiter_pkg.sv
// ============================================================================
// Module   : eth_tx_noc_arbiter_pkg
// Purpose  : Flit layouts, sizing constants and FSM encoding shared by the
//            Ethernet TX NoC merge logic.
// Revision : 1.0 - initial release
// ============================================================================
`ifndef NOC_DATA_WIDTH
`define NOC_DATA_WIDTH 512
`endif

`default_nettype none

package eth_tx_noc_arbiter_pkg;

    localparam int NOC_DATA_WIDTH_P   = `NOC_DATA_WIDTH;
    localparam int ETH_TX_FLIT_BYTES  = `NOC_DATA_WIDTH / 8;
    localparam int MSG_LEN_W          = 22;
    localparam int PAYLOAD_SIZE_W     = 16;

    typedef struct packed {
        logic [13:0]          dst_chip_id;
        logic [7:0]           dst_x;
        logic [7:0]           dst_y;
        logic [3:0]           dst_fbits;
        logic [MSG_LEN_W-1:0] msg_len;
        logic [7:0]           msg_type;
        logic [13:0]          src_chip_id;
        logic [7:0]           src_x;
        logic [7:0]           src_y;
        logic [3:0]           src_fbits;
    } noc_hdr_core_t;

    localparam int NOC_HDR_CORE_W = $bits(noc_hdr_core_t);

    typedef struct packed {
        noc_hdr_core_t                                core;
        logic [NOC_DATA_WIDTH_P-NOC_HDR_CORE_W-1:0]   padding;
    } data_noc_hdr_flit;

    typedef struct packed {
        noc_hdr_core_t                                               core;
        logic [PAYLOAD_SIZE_W-1:0]                                   payload_size;
        logic [NOC_DATA_WIDTH_P-NOC_HDR_CORE_W-PAYLOAD_SIZE_W-1:0]   padding;
    } eth_tx_metadata_flit;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        PASS = 1'b1
    } eth_tx_arb_state_e;

    function automatic logic [MSG_LEN_W-1:0] hdr_msg_len(input data_noc_hdr_flit flit);
        return flit.core.msg_len;
    endfunction

    function automatic logic [PAYLOAD_SIZE_W-1:0] meta_payload_size(input eth_tx_metadata_flit flit);
        return flit.payload_size;
    endfunction

    // Body flits a message should occupy: metadata flit plus rounded-up payload.
    function automatic logic [31:0] eth_tx_exp_flits(input logic [PAYLOAD_SIZE_W-1:0] payload_size);
        return 32'd1 + ((32'(payload_size) + 32'(ETH_TX_FLIT_BYTES - 1)) / 32'(ETH_TX_FLIT_BYTES));
    endfunction

endpackage

`default_nettype wire

// File: rtl/eth_tx_noc_arbiter_if.sv
// ============================================================================
// Module   : eth_tx_noc_arbiter_if
// Purpose  : Many-source to single-destination NoC valid/ready bundle.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface eth_tx_noc_arbiter_if #(
    parameter int NUM_SRCS   = 4,
    parameter int NOC_DATA_W = `NOC_DATA_WIDTH
);
    logic [NUM_SRCS-1:0]            src_arb_val;
    logic [NUM_SRCS*NOC_DATA_W-1:0] src_arb_data;
    logic [NUM_SRCS-1:0]            arb_src_rdy;
    logic                           arb_dst_val;
    logic [NOC_DATA_W-1:0]          arb_dst_data;
    logic                           dst_arb_rdy;

    modport master (
        output src_arb_val, src_arb_data, dst_arb_rdy,
        input  arb_src_rdy, arb_dst_val, arb_dst_data
    );

    modport slave (
        input  src_arb_val, src_arb_data, dst_arb_rdy,
        output arb_src_rdy, arb_dst_val, arb_dst_data
    );
endinterface

`default_nettype wire

// File: rtl/eth_tx_noc_arbiter_rr.sv
// ============================================================================
// Module   : rr_arbiter_onehot
// Purpose  : Combinational round-robin pick: first request at or after ptr.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rr_arbiter_onehot #(
    parameter int N     = 4,
    parameter int PTR_W = $clog2(N)
) (
    input  wire logic [N-1:0]     i_req,
    input  wire logic [PTR_W-1:0] i_ptr,
    output logic      [N-1:0]     o_grant
);

    logic [PTR_W-1:0] w_idx;

    // Scan from the farthest offset down so the nearest request wins last.
    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        for (int off = N - 1; off >= 0; off--) begin
            w_idx = PTR_W'((int'(i_ptr) + off) % N);
            if (i_req[w_idx]) begin
                o_grant        = '0;
                o_grant[w_idx] = 1'b1;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/eth_tx_noc_arbiter.sv
// ============================================================================
// Module   : eth_tx_noc_arbiter
// Purpose  : Message-locked round-robin merge of NoC sources into Eth TX.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module eth_tx_noc_arbiter
    import eth_tx_noc_arbiter_pkg::*;
#(
    parameter int NUM_SRCS   = 4,
    parameter int NOC_DATA_W = `NOC_DATA_WIDTH,
    parameter int CNT_W      = 32
) (
    input  wire logic             clk,
    input  wire logic             rst,
    eth_tx_noc_arbiter_if.slave   bus,
    output logic [NUM_SRCS-1:0]   grant_oh,
    output logic                  busy,
    output logic                  len_err,
    output logic [CNT_W-1:0]      msg_cnt
);

    localparam int PTR_W = $clog2(NUM_SRCS);

    eth_tx_arb_state_e      state_q, state_d;
    logic [PTR_W-1:0]       rr_ptr_q, rr_ptr_d;
    logic [NUM_SRCS-1:0]    grant_q, grant_d;
    logic [MSG_LEN_W-1:0]   flit_cnt_q, flit_cnt_d;
    logic [MSG_LEN_W-1:0]   msg_len_q, msg_len_d;
    logic [CNT_W-1:0]       msg_cnt_q, msg_cnt_d;
    logic                   len_err_q, len_err_d;

    logic [NUM_SRCS-1:0]    w_arb_oh;
    logic [NUM_SRCS-1:0]    w_sel_oh;
    logic [PTR_W-1:0]       w_sel_idx;
    logic [NOC_DATA_W-1:0]  w_dst_data;
    logic                   w_dst_val;
    logic                   w_xfer;
    logic                   w_done;
    logic [MSG_LEN_W-1:0]   w_hdr_len;
    logic [CNT_W-1:0]       w_exp_len;

    rr_arbiter_onehot #(
        .N     (NUM_SRCS),
        .PTR_W (PTR_W)
    ) u_rr (
        .i_req   (bus.src_arb_val),
        .i_ptr   (rr_ptr_q),
        .o_grant (w_arb_oh)
    );

    // Fresh arbitration only in IDLE; PASS stays locked to the owner.
    always_comb begin
        w_sel_oh   = (state_q == IDLE) ? w_arb_oh : grant_q;
        w_dst_data = '0;
        w_sel_idx  = '0;
        for (int i = 0; i < NUM_SRCS; i++) begin
            if (w_sel_oh[i]) begin
                w_dst_data = bus.src_arb_data[i*NOC_DATA_W +: NOC_DATA_W];
                w_sel_idx  = PTR_W'(i);
            end
        end
        w_dst_val = !rst && (|(bus.src_arb_val & w_sel_oh));
    end

    assign w_xfer    = w_dst_val && bus.dst_arb_rdy;
    assign w_hdr_len = hdr_msg_len(w_dst_data);
    assign w_exp_len = CNT_W'(eth_tx_exp_flits(meta_payload_size(w_dst_data)));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        flit_cnt_d = flit_cnt_q;
        msg_len_d  = msg_len_q;
        msg_cnt_d  = msg_cnt_q;
        len_err_d  = 1'b0;
        w_done     = 1'b0;
        case (state_q)
            IDLE: begin
                if (w_xfer) begin
                    msg_len_d  = w_hdr_len;
                    flit_cnt_d = w_hdr_len;
                    if (w_hdr_len == '0) begin
                        w_done = 1'b1;
                    end else begin
                        state_d = PASS;
                        grant_d = w_arb_oh;
                    end
                end
            end
            PASS: begin
                if (w_xfer) begin
                    flit_cnt_d = flit_cnt_q - MSG_LEN_W'(1);
                    // Counter still equal to msg_len means this is the metadata flit.
                    if (flit_cnt_q == msg_len_q) begin
                        len_err_d = (w_exp_len != CNT_W'(msg_len_q));
                    end
                    if (flit_cnt_q == MSG_LEN_W'(1)) begin
                        w_done  = 1'b1;
                        state_d = IDLE;
                        grant_d = '0;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (w_done) begin
            msg_cnt_d = msg_cnt_q + CNT_W'(1);
            rr_ptr_d  = (w_sel_idx == PTR_W'(NUM_SRCS - 1)) ? '0 : w_sel_idx + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            grant_q    <= '0;
            flit_cnt_q <= '0;
            msg_len_q  <= '0;
            msg_cnt_q  <= '0;
            len_err_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            flit_cnt_q <= flit_cnt_d;
            msg_len_q  <= msg_len_d;
            msg_cnt_q  <= msg_cnt_d;
            len_err_q  <= len_err_d;
        end
    end

    assign bus.arb_dst_val  = w_dst_val;
    assign bus.arb_dst_data = w_dst_data;
    assign bus.arb_src_rdy  = rst ? '0 : ({NUM_SRCS{bus.dst_arb_rdy}} & w_sel_oh);
    assign grant_oh         = grant_q;
    assign busy             = (state_q == PASS);
    assign len_err          = len_err_q;
    assign msg_cnt          = msg_cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_eth_tx_noc_arbiter.sv
// ============================================================================
// Module   : tb_eth_tx_noc_arbiter
// Purpose  : Directed scenario bench for the Eth TX NoC arbiter.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_eth_tx_noc_arbiter;
    import eth_tx_noc_arbiter_pkg::*;

    localparam int N  = 4;
    localparam int W  = `NOC_DATA_WIDTH;
    localparam int CW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic [N-1:0]  grant_oh;
    logic          busy;
    logic          len_err;
    logic [CW-1:0] msg_cnt;

    int checks = 0;
    int errors = 0;

    bit src_on  [N];
    int src_len [N];
    int src_ps  [N];
    int src_pos [N];

    eth_tx_noc_arbiter_if #(.NUM_SRCS(N), .NOC_DATA_W(W)) bus ();

    eth_tx_noc_arbiter #(.NUM_SRCS(N), .NOC_DATA_W(W), .CNT_W(CW)) dut (
        .clk      (clk),
        .rst      (rst),
        .bus      (bus),
        .grant_oh (grant_oh),
        .busy     (busy),
        .len_err  (len_err),
        .msg_cnt  (msg_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    function automatic logic [W-1:0] flit_of(input int src, input int pos);
        data_noc_hdr_flit    h;
        eth_tx_metadata_flit m;
        logic [W-1:0]        b;
        h = '0;
        m = '0;
        if (pos == 0) begin
            h.core.msg_len  = MSG_LEN_W'(src_len[src]);
            h.core.src_x    = 8'(src);
            h.core.msg_type = 8'h5A;
            return h;
        end else if (pos == 1) begin
            m.core.src_x    = 8'(src);
            m.payload_size  = 16'(src_ps[src]);
            return m;
        end
        b = {(W/32){32'hB0D0_0000 | 32'(src << 8) | 32'(pos)}};
        return b;
    endfunction

    task automatic apply();
        for (int i = 0; i < N; i++) begin
            bus.src_arb_val[i]            = src_on[i];
            bus.src_arb_data[i*W +: W]    = flit_of(i, src_pos[i]);
        end
        #1;
    endtask

    // Advance one clock; each source that handshook moves to its next flit.
    task automatic step();
        logic [N-1:0] x;
        x = bus.src_arb_val & bus.arb_src_rdy;
        @(posedge clk);
        #1;
        for (int i = 0; i < N; i++)
            if (x[i]) src_pos[i] = (src_pos[i] + 1) % (src_len[i] + 1);
        apply();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        bus.dst_arb_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_on[i] = 1'b0; src_len[i] = 0; src_ps[i] = 0; src_pos[i] = 0;
        end
        apply();
        @(posedge clk);
        #1;
        rst = 1'b0;
        apply();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.dst_arb_rdy = 1'b1;
        for (int i = 0; i < N; i++) begin
            src_on[i] = 1'b1; src_len[i] = 1; src_ps[i] = 0; src_pos[i] = 0;
        end
        apply();
        checks++; if (bus.arb_dst_val !== 1'b0) begin errors++; $display("FAIL rst_dst_val got %b exp 0", bus.arb_dst_val); end
        checks++; if (bus.arb_src_rdy !== 4'b0000) begin errors++; $display("FAIL rst_src_rdy got %b exp 0000", bus.arb_src_rdy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        for (int i = 0; i < N; i++) src_on[i] = 1'b0;
        apply();
        checks++; if (grant_oh !== 4'b0000) begin errors++; $display("FAIL rst_grant got %b exp 0000", grant_oh); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %b exp 0", busy); end
        checks++; if (msg_cnt !== 32'd0) begin errors++; $display("FAIL rst_msg_cnt got %0d exp 0", msg_cnt); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL rst_len_err got %b exp 0", len_err); end
    endtask

    task automatic test_single();
        do_reset();
        src_on[0] = 1'b1; src_len[0] = 2; src_ps[0] = 64;
        apply();
        checks++; if (bus.arb_dst_val !== 1'b1) begin errors++; $display("FAIL single_hdr_val got %b exp 1", bus.arb_dst_val); end
        checks++; if (bus.arb_src_rdy !== 4'b0001) begin errors++; $display("FAIL single_hdr_rdy got %b exp 0001", bus.arb_src_rdy); end
        checks++; if (bus.arb_dst_data !== flit_of(0, 0)) begin errors++; $display("FAIL single_hdr_data got %h exp %h", bus.arb_dst_data[31:0], flit_of(0, 0) >> 0); end
        checks++; if (grant_oh !== 4'b0000) begin errors++; $display("FAIL single_hdr_grant got %b exp 0000", grant_oh); end
        step();
        checks++; if (grant_oh !== 4'b0001) begin errors++; $display("FAIL single_meta_grant got %b exp 0001", grant_oh); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_meta_busy got %b exp 1", busy); end
        checks++; if (bus.arb_dst_data !== flit_of(0, 1)) begin errors++; $display("FAIL single_meta_data got %h exp %h", bus.arb_dst_data[31:0], flit_of(0, 1) >> 0); end
        step();
        checks++; if (bus.arb_dst_data !== flit_of(0, 2) || bus.arb_dst_val !== 1'b1) begin errors++; $display("FAIL single_body got %h/%b exp %h/1", bus.arb_dst_data[31:0], bus.arb_dst_val, flit_of(0, 2) >> 0); end
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL single_len_err got %b exp 0", len_err); end
        checks++; if (grant_oh !== 4'b0001) begin errors++; $display("FAIL single_body_grant got %b exp 0001", grant_oh); end
        step();
        src_on[0] = 1'b0;
        apply();
        checks++; if (msg_cnt !== 32'd1) begin errors++; $display("FAIL single_msg_cnt got %0d exp 1", msg_cnt); end
        checks++; if (busy !== 1'b0 || grant_oh !== 4'b0000) begin errors++; $display("FAIL single_end got busy %b grant %b exp 0 0000", busy, grant_oh); end
        checks++; if (bus.arb_dst_val !== 1'b0) begin errors++; $display("FAIL single_end_val got %b exp 0", bus.arb_dst_val); end
    endtask

    task automatic test_interleave();
        int e;
        do_reset();
        src_on[0] = 1'b1; src_len[0] = 3; src_ps[0] = 128;
        src_on[2] = 1'b1; src_len[2] = 3; src_ps[2] = 128;
        apply();
        for (int k = 0; k < 16; k++) begin
            e = ((k / 4) % 2 == 0) ? 0 : 2;
            checks++; if (bus.arb_dst_val !== 1'b1 || bus.arb_src_rdy !== 4'(1 << e)) begin errors++; $display("FAIL rr_owner cyc %0d got val %b rdy %b exp 1 %b", k, bus.arb_dst_val, bus.arb_src_rdy, 4'(1 << e)); end
            checks++; if (bus.arb_dst_data !== flit_of(e, k % 4)) begin errors++; $display("FAIL rr_data cyc %0d got %h exp %h", k, bus.arb_dst_data[31:0], flit_of(e, k % 4) >> 0); end
            step();
        end
        checks++; if (msg_cnt !== 32'd4) begin errors++; $display("FAIL rr_msg_cnt got %0d exp 4", msg_cnt); end
    endtask

    task automatic test_bubble();
        do_reset();
        src_on[0] = 1'b1; src_len[0] = 3; src_ps[0] = 128;
        src_on[1] = 1'b1; src_len[1] = 2; src_ps[1] = 64;
        apply();
        checks++; if (bus.arb_src_rdy !== 4'b0001) begin errors++; $display("FAIL bub_first got %b exp 0001", bus.arb_src_rdy); end
        step();
        step();
        src_on[0] = 1'b0;
        apply();
        for (int k = 0; k < 2; k++) begin
            checks++; if (bus.arb_dst_val !== 1'b0 || bus.arb_src_rdy[1] !== 1'b0) begin errors++; $display("FAIL bub_hold cyc %0d got val %b rdy %b exp 0 x0xx", k, bus.arb_dst_val, bus.arb_src_rdy); end
            checks++; if (grant_oh !== 4'b0001) begin errors++; $display("FAIL bub_grant cyc %0d got %b exp 0001", k, grant_oh); end
            step();
        end
        src_on[0] = 1'b1;
        apply();
        checks++; if (bus.arb_dst_data !== flit_of(0, 2) || bus.arb_src_rdy !== 4'b0001) begin errors++; $display("FAIL bub_resume got %h rdy %b exp %h 0001", bus.arb_dst_data[31:0], bus.arb_src_rdy, flit_of(0, 2) >> 0); end
        step();
        checks++; if (bus.arb_dst_data !== flit_of(0, 3) || busy !== 1'b1) begin errors++; $display("FAIL bub_last got %h busy %b exp %h 1", bus.arb_dst_data[31:0], busy, flit_of(0, 3) >> 0); end
        step();
        checks++; if (bus.arb_src_rdy !== 4'b0010 || bus.arb_dst_data !== flit_of(1, 0)) begin errors++; $display("FAIL bub_next got rdy %b data %h exp 0010 %h", bus.arb_src_rdy, bus.arb_dst_data[31:0], flit_of(1, 0) >> 0); end
        checks++; if (msg_cnt !== 32'd1) begin errors++; $display("FAIL bub_msg_cnt got %0d exp 1", msg_cnt); end
    endtask

    task automatic test_stall();
        do_reset();
        src_on[0] = 1'b1; src_len[0] = 3; src_ps[0] = 128;
        apply();
        step();
        step();
        bus.dst_arb_rdy = 1'b0;
        apply();
        for (int k = 0; k < 5; k++) begin
            checks++; if (bus.arb_dst_val !== 1'b1 || bus.arb_dst_data !== flit_of(0, 2)) begin errors++; $display("FAIL stall_hold cyc %0d got %b %h exp 1 %h", k, bus.arb_dst_val, bus.arb_dst_data[31:0], flit_of(0, 2) >> 0); end
            checks++; if (bus.arb_src_rdy !== 4'b0000 || busy !== 1'b1) begin errors++; $display("FAIL stall_rdy cyc %0d got rdy %b busy %b exp 0000 1", k, bus.arb_src_rdy, busy); end
            step();
        end
        bus.dst_arb_rdy = 1'b1;
        apply();
        step();
        checks++; if (bus.arb_dst_data !== flit_of(0, 3) || busy !== 1'b1) begin errors++; $display("FAIL stall_last got %h busy %b exp %h 1", bus.arb_dst_data[31:0], busy, flit_of(0, 3) >> 0); end
        step();
        src_on[0] = 1'b0;
        apply();
        checks++; if (busy !== 1'b0 || msg_cnt !== 32'd1) begin errors++; $display("FAIL stall_end got busy %b cnt %0d exp 0 1", busy, msg_cnt); end
    endtask

    task automatic test_len_err();
        do_reset();
        src_on[0] = 1'b1; src_len[0] = 2; src_ps[0] = 100;
        apply();
        step();
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL lerr_pre got %b exp 0", len_err); end
        step();
        checks++; if (len_err !== 1'b1) begin errors++; $display("FAIL lerr_pulse got %b exp 1", len_err); end
        checks++; if (bus.arb_dst_val !== 1'b1 || bus.arb_dst_data !== flit_of(0, 2)) begin errors++; $display("FAIL lerr_fwd got %b %h exp 1 %h", bus.arb_dst_val, bus.arb_dst_data[31:0], flit_of(0, 2) >> 0); end
        step();
        src_on[0] = 1'b0;
        apply();
        checks++; if (len_err !== 1'b0) begin errors++; $display("FAIL lerr_post got %b exp 0", len_err); end
        checks++; if (msg_cnt !== 32'd1 || busy !== 1'b0) begin errors++; $display("FAIL lerr_end got cnt %0d busy %b exp 1 0", msg_cnt, busy); end
    endtask

    task automatic test_reset_mid();
        src_on[3] = 1'b1; src_len[3] = 4; src_ps[3] = 192;
        apply();
        checks++; if (bus.arb_src_rdy !== 4'b1000) begin errors++; $display("FAIL rmid_hdr got %b exp 1000", bus.arb_src_rdy); end
        step();
        step();
        checks++; if (bus.arb_dst_data !== flit_of(3, 2) || busy !== 1'b1) begin errors++; $display("FAIL rmid_body got %h busy %b exp %h 1", bus.arb_dst_data[31:0], busy, flit_of(3, 2) >> 0); end
        rst = 1'b1;
        #1;
        checks++; if (bus.arb_dst_val !== 1'b0 || bus.arb_src_rdy !== 4'b0000) begin errors++; $display("FAIL rmid_force got val %b rdy %b exp 0 0000", bus.arb_dst_val, bus.arb_src_rdy); end
        @(posedge clk);
        #1;
        rst = 1'b0;
        src_pos[3] = 0;
        apply();
        checks++; if (busy !== 1'b0 || grant_oh !== 4'b0000 || msg_cnt !== 32'd0) begin errors++; $display("FAIL rmid_after got busy %b grant %b cnt %0d exp 0 0000 0", busy, grant_oh, msg_cnt); end
        checks++; if (bus.arb_src_rdy !== 4'b1000 || bus.arb_dst_data !== flit_of(3, 0)) begin errors++; $display("FAIL rmid_rehdr got rdy %b data %h exp 1000 %h", bus.arb_src_rdy, bus.arb_dst_data[31:0], flit_of(3, 0) >> 0); end
        for (int k = 0; k < 5; k++) step();
        src_on[3] = 1'b0;
        apply();
        checks++; if (msg_cnt !== 32'd1 || busy !== 1'b0) begin errors++; $display("FAIL rmid_done got cnt %0d busy %b exp 1 0", msg_cnt, busy); end
    endtask

    task automatic test_len_zero_back_to_back();
        int e;
        do_reset();
        src_on[1] = 1'b1; src_len[1] = 0;
        src_on[2] = 1'b1; src_len[2] = 0;
        apply();
        for (int k = 0; k < 4; k++) begin
            e = (k % 2 == 0) ? 1 : 2;
            checks++; if (bus.arb_src_rdy !== 4'(1 << e) || bus.arb_dst_data !== flit_of(e, 0)) begin errors++; $display("FAIL zlen_owner cyc %0d got rdy %b exp %b", k, bus.arb_src_rdy, 4'(1 << e)); end
            checks++; if (busy !== 1'b0 || msg_cnt !== 32'(k)) begin errors++; $display("FAIL zlen_state cyc %0d got busy %b cnt %0d exp 0 %0d", k, busy, msg_cnt, k); end
            step();
        end
        src_on[1] = 1'b0;
        src_on[2] = 1'b0;
        apply();
        checks++; if (msg_cnt !== 32'd4 || busy !== 1'b0 || grant_oh !== 4'b0000) begin errors++; $display("FAIL zlen_end got cnt %0d busy %b grant %b exp 4 0 0000", msg_cnt, busy, grant_oh); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_interleave();
        test_bubble();
        test_stall();
        test_len_err();
        test_reset_mid();
        test_len_zero_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
